tick_timer: RTL
===============

TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter WIDTH, default 32, counter and period width (2..32).
REQ-002 Parameter PRESC_WIDTH, default 8, prescaler divisor width; used only when TICK_TIMER_PRESCALE_EN is defined.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  count enable.
REQ-006 clr  in  1  synchronous clear.
REQ-007 load  in  1  synchronous load strobe.
REQ-008 load_val  in  WIDTH  value taken on load.
REQ-009 period  in  WIDTH  terminal count.
REQ-010 mode  in  1  0 = periodic (auto-wrap), 1 = one-shot.
REQ-011 presc  in  PRESC_WIDTH  divisor minus one; port present only with TICK_TIMER_PRESCALE_EN.
REQ-012 count  out  WIDTH  current count, registered.
REQ-013 tick  out  1  one-cycle terminal-count pulse, registered.
REQ-014 done  out  1  sticky one-shot completion flag, registered.
REQ-015 running  out  1  combinational en AND NOT done.

Function
REQ-016 A step occurs on a clock edge where en=1, the prescaler strobe is 1, and done=0.
REQ-017 Priority per edge: clr > load > step > hold.
REQ-018 clr: count=0, tick=0, done=0, prescaler count=0.
REQ-019 load: count=load_val, tick=0, done=0, prescaler count=0.
REQ-020 Step with count < period: count=count+1, tick=0.
REQ-021 Step with count >= period, mode=0: count=0, tick=1 for exactly the following cycle.
REQ-022 Step with count >= period, mode=1: count holds, tick=1 for one cycle, done=1.
REQ-023 While done=1, steps are suppressed; only clr, load or rst clear done.
REQ-024 The compare uses >=, so a period lowered below count terminates at the next step without wrapping through 2^WIDTH.
REQ-025 period=0, mode=0: count stays 0 and tick asserts on every step.
REQ-026 tick is 0 on every cycle with no terminal step; back-to-back ticks occur only when consecutive steps are terminal.
REQ-027 mode and period are sampled every edge; a change takes effect at the next step.
REQ-028 en=0 holds count, prescaler count and done; tick deasserts.
REQ-029 Arithmetic is unsigned WIDTH-bit; count never exceeds max(period, load_val).

Reset
REQ-030 On rst=1, asynchronously: count=0, tick=0, done=0, prescaler count=0.
REQ-031 Reset asserted mid-count aborts immediately; counting resumes on the first edge after deassertion with en=1.

Configuration
REQ-032 Macro TICK_TIMER_PRESCALE_EN defined: strobe pulses once every presc+1 enabled cycles; presc=0 gives a strobe every enabled cycle.
REQ-033 A presc change takes effect when the prescaler count next reaches its terminal value or is cleared.
REQ-034 Macro undefined: no presc port or prescaler logic; strobe is constant 1.

Structure
REQ-035 Package tick_timer_pkg holds the mode constants MODE_PERIODIC=1'b0 and MODE_ONESHOT=1'b1, plus default WIDTH/PRESC_WIDTH constants.
REQ-036 Sub-module tick_prescaler (clk, rst, en, clr, presc -> strobe) is instantiated only under TICK_TIMER_PRESCALE_EN.

Verification
REQ-037 WIDTH=8, mode=0, period=3, en=1, presc=0 -> count 0,1,2,3,0,...; tick high one cycle after each 3->0 transition, every 4 cycles.
REQ-038 mode=1, period=5 -> count stops at 5; one tick; done=1 and running=0 thereafter; clr -> count=0, done=0.
REQ-039 Count=200 (WIDTH=8), period changed to 10 -> next step gives count=0 and tick=1; no wrap via 255.
REQ-040 clr and load both asserted with load_val=7 -> count=0; load alone -> count=7 on the next edge.
REQ-041 With the macro, presc=2, period=1 -> count advances every 3 cycles; tick every 6 cycles.
REQ-042 rst pulsed asynchronously mid-count at count=9 -> count=0, tick=0 and done=0 before the next edge; counting resumes after deassertion.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// Shared constants for the tick timer: mode encodings and default widths.
package tick_timer_pkg;

   localparam logic MODE_PERIODIC       = 1'b0;
   localparam logic MODE_ONESHOT        = 1'b1;

   localparam int   DEFAULT_WIDTH       = 32;
   localparam int   DEFAULT_PRESC_WIDTH = 8;

endpackage

// File: rtl/tick_timer_prescaler.sv
// Tick prescaler: strobes once every presc+1 enabled cycles.
// The whole module exists only when TICK_TIMER_PRESCALE_EN is defined.
`ifdef TICK_TIMER_PRESCALE_EN
module tick_prescaler
   import tick_timer_pkg::*;
#(
   parameter int PRESC_WIDTH = DEFAULT_PRESC_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic [PRESC_WIDTH-1:0] presc,
   output logic                   strobe
);

   logic [PRESC_WIDTH-1:0] cnt_q;
   logic [PRESC_WIDTH-1:0] cnt_d;

   // Terminal test uses >= so a lowered divisor never wraps through the
   // full prescaler range before the next strobe.
   assign strobe = (cnt_q >= presc);

   // Next prescaler count: clear wins, then advance/restart while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {PRESC_WIDTH{1'b0}};
      end else if (en) begin
         if (strobe) begin
            cnt_d = {PRESC_WIDTH{1'b0}};
         end else begin
            cnt_d = cnt_q + {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Prescaler count register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {PRESC_WIDTH{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/tick_timer.sv
// Tick timer: periodic or one-shot up-counter with terminal-count tick.
// Optional prescaler enabled by defining TICK_TIMER_PRESCALE_EN.
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int PRESC_WIDTH = DEFAULT_PRESC_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic                   load,
   input  logic [WIDTH-1:0]       load_val,
   input  logic [WIDTH-1:0]       period,
   input  logic                   mode,
`ifdef TICK_TIMER_PRESCALE_EN
   input  logic [PRESC_WIDTH-1:0] presc,
`endif
   output logic [WIDTH-1:0]       count,
   output logic                   tick,
   output logic                   done,
   output logic                   running
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tick_q;
   logic             tick_d;
   logic             done_q;
   logic             done_d;
   logic             strobe_s;
   logic             step_s;

`ifdef TICK_TIMER_PRESCALE_EN
   // Load restarts the prescaler phase just like clear does.
   tick_prescaler #(
      .PRESC_WIDTH (PRESC_WIDTH)
   ) u_presc (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .clr    (clr | load),
      .presc  (presc),
      .strobe (strobe_s)
   );
`else
   assign strobe_s = 1'b1;
`endif

   assign step_s  = en & strobe_s & ~done_q;
   assign count   = count_q;
   assign tick    = tick_q;
   assign done    = done_q;
   assign running = en & ~done_q;

   // Next-state: clr > load > step > hold; tick is a single-cycle pulse.
   always_comb begin
      count_d = count_q;
      tick_d  = 1'b0;
      done_d  = done_q;
      if (clr) begin
         count_d = {WIDTH{1'b0}};
         done_d  = 1'b0;
      end else if (load) begin
         count_d = load_val;
         done_d  = 1'b0;
      end else if (step_s) begin
         if (count_q >= period) begin
            tick_d = 1'b1;
            if (mode == MODE_PERIODIC) begin
               count_d = {WIDTH{1'b0}};
            end else begin
               count_d = count_q;
               done_d  = 1'b1;
            end
         end else begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end else begin
         count_d = count_q;
      end
   end

   // Timer state registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {WIDTH{1'b0}};
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

endmodule
